counter_prescaled: RTL and testbench
====================================

Name: counter_prescaled

Overview:
Parametrised successor to the team's fixed free-running divider counter. It provides a programmable prescaler feeding a modulo up/down counter, with free-run and one-shot modes, parallel load, enable and synchronous reset. It exports the top OUT_BITS of the count as a slow display/scan index, the same way the fixed counter does, plus step and wrap pulses. It sits beside the display/scan logic and fuzzy-controller sampling timers as the general time base.

Parameters:
CNT_WIDTH, 20, width of main counter.
PRE_WIDTH, 8, width of prescaler counter and prescale input.
OUT_BITS, 3, number of MSBs exported on count (OUT_BITS <= CNT_WIDTH).
AUTO_START, 1, 1: leave reset in RUN; 0: leave reset in IDLE.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  count enable; low freezes prescaler and counter.
start  in  1  IDLE/DONE -> RUN request.
mode  in  1  0 free-run, 1 one-shot.
dir  in  1  0 up, 1 down.
load  in  1  parallel load strobe.
load_val  in  CNT_WIDTH  load value.
prescale  in  PRE_WIDTH  divide ratio minus one (step every prescale+1 enabled cycles).
modulo  in  CNT_WIDTH  terminal value; counter range is 0..modulo.
value  out  CNT_WIDTH  full counter value.
count  out  OUT_BITS  value[CNT_WIDTH-1 -: OUT_BITS].
tick  out  1  one-cycle pulse, aligned with each counter update.
wrap  out  1  one-cycle pulse, aligned with a wrap update.
busy  out  1  high in RUN.
done  out  1  high in DONE.

Behaviour:
- All outputs are registered; count and busy/done are decoded directly from registers.
- Reset (rst=1 at clk edge) overrides everything:
  - value=0, pre_cnt=0, tick=0, wrap=0.
  - State = RUN if AUTO_START else IDLE, so busy=AUTO_START and done=0.
- States:
  - IDLE: no counting.
  - RUN: counting.
  - DONE: one-shot complete; no counting.
  - start in IDLE or DONE -> RUN with pre_cnt=0; start in RUN is ignored.
- Priority per cycle: rst > load > step.
  - load: value<=load_val and pre_cnt<=0 in any state, with no state change and tick=wrap=0 that cycle. A step coinciding with load is discarded.
- Prescaler, active only in RUN with en=1:
  - if pre_cnt >= prescale, then step=1 and pre_cnt<=0; else pre_cnt+1.
  - prescale=0 steps every enabled cycle.
  - The >= compare makes a prescale reduction mid-count take effect at once, with no long wrap.
- Step, up (dir=0): if value >= modulo, value<=0 and wrap=1; else value+1.
- Step, down (dir=1): if value==0 or value>modulo, value<=modulo and wrap=1; else value-1.
- tick=1 on every step update; both tick and wrap are high for exactly the cycle the new value is visible.
- One-shot (mode=1): if the step's new value equals the terminal (modulo when up, 0 when down), state -> DONE in the same edge. done rises with the terminal value and value then holds.
  - Restart from the terminal value is legal: the first step wraps (wrap=1) and counting continues normally.
- en=0 freezes pre_cnt, value and state; tick=wrap=0. load, start and rst still act.
- mode/dir changes are legal at any time and take effect from the next step.
- modulo=0: up steps give value 0 with wrap every step. In one-shot, an up step from value 0 wraps to 0, which equals the terminal, so the state goes to DONE on that first step.
- Defaults (CNT_WIDTH=20, OUT_BITS=3, AUTO_START=1, prescale=0, modulo=all-ones, en=1, mode=0, dir=0) give count identical to the fixed 20-bit divider's counter[19:17].

Test Plan:
1. Defaults, rst for 1 cycle then en=1 -> value increments every cycle; count=1 exactly 2^17 cycles after reset release; after 2^20 cycles value=0 with wrap=1 for one cycle.
2. prescale=3, modulo=4, up, free-run -> tick every 4th cycle; value 0,1,2,3,4,0; wrap only on the 4->0 update; pre_cnt frozen while en pulsed low for 5 cycles, so the tick slips by exactly 5.
3. dir=1, modulo=5, value=0, prescale=0 -> next value 5 with wrap=1, then 4,3,2,1,0,5.
4. AUTO_START=0, mode=1, modulo=3, up, pulse start -> busy=1; value 1,2,3; done=1 and busy=0 with value 3 and it holds. A second start gives 0 (wrap=1),1,2,3 and then done.
5. RUN with prescale=7, load=1 with load_val=10 mid-prescale (including the same cycle as a step) -> value=10, no tick that cycle, next tick exactly 8 enabled cycles later with value 11.
6. rst asserted mid-count with en=1, load=1 and start=1 in the same cycle -> next cycle value=0, tick=wrap=done=0, busy=AUTO_START; load is ignored.

Source files
------------

// File: rtl/counter_prescaled.sv
// Programmable prescaler driving a modulo up/down counter with free-run and one-shot modes.
// Exports the top OUT_BITS of the count as a slow scan index, plus step (tick) and wrap pulses.
module counter_prescaled #(
  parameter int unsigned CNT_WIDTH  = 20,
  parameter int unsigned PRE_WIDTH  = 8,
  parameter int unsigned OUT_BITS   = 3,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 dir,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0] modulo,
  output logic [CNT_WIDTH-1:0] value,
  output logic [OUT_BITS-1:0]  count,
  output logic                 tick,
  output logic                 wrap,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] value_q, value_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0] term_c;

  // One-shot stops on the value a step in the current direction ends on.
  assign term_c = dir ? '0 : modulo;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AUTO_START ? ST_RUN : ST_IDLE;
      value_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state: load beats start, start beats stepping.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      value_d = load_val;
      pre_d   = '0;
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      pre_d   = '0;
    end else if ((state_q == ST_RUN) && en) begin
      // >= so that lowering prescale mid-count steps immediately.
      if (pre_q >= prescale) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (!dir) begin
          if (value_q >= modulo) begin
            value_d = '0;
            wrap_d  = 1'b1;
          end else begin
            value_d = value_q + CNT_WIDTH'(1);
          end
        end else begin
          if ((value_q == '0) || (value_q > modulo)) begin
            value_d = modulo;
            wrap_d  = 1'b1;
          end else begin
            value_d = value_q - CNT_WIDTH'(1);
          end
        end
        if (mode && (value_d == term_c)) begin
          state_d = ST_DONE;
        end
      end else begin
        pre_d = pre_q + PRE_WIDTH'(1);
      end
    end
  end

  assign value = value_q;
  assign count = value_q[CNT_WIDTH-1 -: OUT_BITS];
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_prescaled.sv
// Bench for counter_prescaled: two instances (AUTO_START=1 and 0) on shared stimulus,
// compared every cycle against a behavioural model plus directed constant checks.
module tb_counter_prescaled;

  localparam int CW = 20;
  localparam int PW = 8;
  localparam int OB = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst, en, start, mode, dir, load;
  logic [CW-1:0] load_val, modulo;
  logic [PW-1:0] prescale;

  logic [CW-1:0] value_a, value_b;
  logic [OB-1:0] count_a, count_b;
  logic          tick_a, wrap_a, busy_a, done_a;
  logic          tick_b, wrap_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_val[2];
  int unsigned m_pre[2];
  int          m_st[2];
  bit          m_tick[2];
  bit          m_wrap[2];

  always #5 clk = ~clk;

  counter_prescaled #(.CNT_WIDTH(CW), .PRE_WIDTH(PW), .OUT_BITS(OB), .AUTO_START(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .prescale(prescale), .modulo(modulo),
    .value(value_a), .count(count_a), .tick(tick_a), .wrap(wrap_a),
    .busy(busy_a), .done(done_a)
  );

  counter_prescaled #(.CNT_WIDTH(CW), .PRE_WIDTH(PW), .OUT_BITS(OB), .AUTO_START(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .prescale(prescale), .modulo(modulo),
    .value(value_b), .count(count_b), .tick(tick_b), .wrap(wrap_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge for both instances (index 0 auto-starts).
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (rst) begin
        m_val[i] = 0;
        m_pre[i] = 0;
        m_st[i]  = (i == 0) ? M_RUN : M_IDLE;
      end else if (load) begin
        m_val[i] = 32'(load_val);
        m_pre[i] = 0;
      end else if (start && m_st[i] != M_RUN) begin
        m_st[i]  = M_RUN;
        m_pre[i] = 0;
      end else if (m_st[i] == M_RUN && en) begin
        if (m_pre[i] >= 32'(prescale)) begin
          m_pre[i]  = 0;
          m_tick[i] = 1'b1;
          if (!dir) begin
            if (m_val[i] >= 32'(modulo)) begin m_val[i] = 0; m_wrap[i] = 1'b1; end
            else m_val[i] = m_val[i] + 1;
          end else begin
            if (m_val[i] == 0 || m_val[i] > 32'(modulo)) begin m_val[i] = 32'(modulo); m_wrap[i] = 1'b1; end
            else m_val[i] = m_val[i] - 1;
          end
          if (mode && m_val[i] == (dir ? 32'd0 : 32'(modulo))) m_st[i] = M_DONE;
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("val_a",  64'(value_a), 64'(m_val[0]));
    check("cnt_a",  64'(count_a), 64'(m_val[0] >> (CW - OB)));
    check("tick_a", 64'(tick_a),  64'(m_tick[0]));
    check("wrap_a", 64'(wrap_a),  64'(m_wrap[0]));
    check("busy_a", 64'(busy_a),  64'(m_st[0] == M_RUN));
    check("done_a", 64'(done_a),  64'(m_st[0] == M_DONE));
    check("val_b",  64'(value_b), 64'(m_val[1]));
    check("cnt_b",  64'(count_b), 64'(m_val[1] >> (CW - OB)));
    check("tick_b", 64'(tick_b),  64'(m_tick[1]));
    check("wrap_b", 64'(wrap_b),  64'(m_wrap[1]));
    check("busy_b", 64'(busy_b),  64'(m_st[1] == M_RUN));
    check("done_b", 64'(done_b),  64'(m_st[1] == M_DONE));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Cycles until instance A ticks, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_a && n < 40);
  endtask

  task automatic set_defaults();
    rst = 1'b0; en = 1'b1; start = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; prescale = '0; modulo = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int exp_up[5]   = '{1, 2, 3, 4, 0};
    int exp_down[7] = '{5, 4, 3, 2, 1, 0, 5};

    set_defaults();

    // Defaults: plain divider behaviour.
    do_reset();
    check("rst_busy_a", 64'(busy_a), 64'd1);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    check("rst_val_a", 64'(value_a), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("t1_inc", 64'(value_a), 64'(k));
    end
    load = 1'b1; load_val = CW'((1 << 17) - 3);
    cycle();
    load = 1'b0;
    check("t1_load_tick", 64'(tick_a), 64'd0);
    cycles(2);
    check("t1_cnt0", 64'(count_a), 64'd0);
    cycle();
    check("t1_cnt1", 64'(count_a), 64'd1);
    load = 1'b1; load_val = CW'((1 << 20) - 2);
    cycle();
    load = 1'b0;
    cycles(2);
    check("t1_wrap_val", 64'(value_a), 64'd0);
    check("t1_wrap", 64'(wrap_a), 64'd1);
    cycle();
    check("t1_wrap_clr", 64'(wrap_a), 64'd0);

    // Prescale 3, modulo 4, then en held low for 5 cycles.
    set_defaults(); prescale = 8'd3; modulo = CW'(4);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_tick(n);
      check("t2_gap", 64'(n), 64'd4);
      check("t2_val", 64'(value_a), 64'(exp_up[k]));
      check("t2_wrap", 64'(wrap_a), 64'(k == 4));
    end
    cycles(2);
    en = 1'b0;
    cycles(5);
    en = 1'b1;
    wait_tick(n);
    check("t2_slip", 64'(7 + n), 64'd9);

    // Down count, modulo 5.
    set_defaults(); dir = 1'b1; modulo = CW'(5);
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cycle();
      check("t3_val", 64'(value_a), 64'(exp_down[k]));
      check("t3_wrap", 64'(wrap_a), 64'(k == 0 || k == 6));
    end

    // One-shot on the non-auto-start instance, including restart from the terminal.
    set_defaults(); mode = 1'b1; modulo = CW'(3);
    do_reset();
    check("t4_idle", 64'(busy_b), 64'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t4_busy", 64'(busy_b), 64'd1);
    check("t4_val0", 64'(value_b), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("t4_val", 64'(value_b), 64'(k));
    end
    check("t4_done", 64'(done_b), 64'd1);
    check("t4_nbusy", 64'(busy_b), 64'd0);
    cycles(3);
    check("t4_hold", 64'(value_b), 64'd3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t4_rbusy", 64'(busy_b), 64'd1);
    cycle();
    check("t4_rval", 64'(value_b), 64'd0);
    check("t4_rwrap", 64'(wrap_b), 64'd1);
    cycles(3);
    check("t4_rdone", 64'(done_b), 64'd1);
    check("t4_rend", 64'(value_b), 64'd3);

    // Load coinciding with a step, then load mid-prescale.
    set_defaults(); prescale = 8'd7; modulo = CW'(1000);
    do_reset();
    cycles(7);
    load = 1'b1; load_val = CW'(10);
    cycle();
    load = 1'b0;
    check("t5_lval", 64'(value_a), 64'd10);
    check("t5_ltick", 64'(tick_a), 64'd0);
    wait_tick(n);
    check("t5_gap", 64'(n), 64'd8);
    check("t5_next", 64'(value_a), 64'd11);
    cycles(3);
    load = 1'b1; load_val = CW'(10);
    cycle();
    load = 1'b0;
    check("t5_mval", 64'(value_a), 64'd10);
    wait_tick(n);
    check("t5_mgap", 64'(n), 64'd8);
    check("t5_mnext", 64'(value_a), 64'd11);

    // Reset wins over load and start in the same cycle.
    set_defaults(); modulo = CW'(1000);
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(5);
    rst = 1'b1; load = 1'b1; load_val = CW'(77); start = 1'b1;
    cycle();
    set_defaults();
    check("t6_val_a", 64'(value_a), 64'd0);
    check("t6_val_b", 64'(value_b), 64'd0);
    check("t6_tick", 64'(tick_a), 64'd0);
    check("t6_wrap", 64'(wrap_a), 64'd0);
    check("t6_done", 64'(done_a), 64'd0);
    check("t6_busy_a", 64'(busy_a), 64'd1);
    check("t6_busy_b", 64'(busy_b), 64'd0);

    // Randomised traffic against the model.
    set_defaults(); modulo = CW'(6);
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 7) != 0);
      load_val = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) modulo = CW'($urandom_range(0, 9));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
